// File: rtl/starfield_scroller_if.sv
// starfield_scroller_if
//   Bundles the pixel-stream signals between the VGA timing generator /
//   pattern logic and the starfield overlay stage.
//
//   Timing-side inputs : display_on, hpos[9:0], vpos[9:0], hsync_in,
//                        vsync_in, bg_rgb[2:0], star_en
//   Overlay outputs    : hsync, vsync, rgb[2:0], frame_cnt[7:0]
//
//   modport master : the side that produces the timing stream and consumes
//                    the overlaid pixels (timing generator / testbench).
//   modport slave  : the starfield_scroller itself.
interface starfield_scroller_if;
  logic       display_on;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync_in;
  logic       vsync_in;
  logic [2:0] bg_rgb;
  logic       star_en;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb;
  logic [7:0] frame_cnt;

  modport master (
    output display_on, hpos, vpos, hsync_in, vsync_in, bg_rgb, star_en,
    input  hsync, vsync, rgb, frame_cnt
  );

  modport slave (
    input  display_on, hpos, vpos, hsync_in, vsync_in, bg_rgb, star_en,
    output hsync, vsync, rgb, frame_cnt
  );
endinterface

// File: rtl/starfield_scroller.sv
// starfield_scroller
//   Pixel-stream stage placed right after the VGA timing generator. Overlays
//   a pseudo-random starfield on the background colour and scrolls it one
//   pixel to the left every SCROLL_DIV frames. Two registered stages; rgb,
//   hsync and vsync are all delayed by exactly two clocks.
//
//   Ports:
//     clk    : pixel clock
//     reset  : asynchronous, active-high reset
//     bus    : starfield_scroller_if.slave
//              in  display_on, hpos, vpos, hsync_in, vsync_in, bg_rgb, star_en
//              out hsync, vsync, rgb, frame_cnt
//
//   Optional build macro: STARFIELD_TWINKLE_EN
//     When defined, stars whose lfsr[3] is set are hidden while frame_cnt[4]
//     is set, so half of the stars blink with a 32-frame period.
module starfield_scroller #(
  parameter int                    LFSR_WIDTH        = 16,
  parameter logic [LFSR_WIDTH-1:0] TAPS              = 16'b1000000001011,
  parameter logic [LFSR_WIDTH-1:0] SEED              = 16'h0001,
  parameter int                    STAR_DENSITY_BITS = 7,
  parameter int                    SCROLL_DIV        = 1,
  parameter int                    H_ACTIVE          = 640,
  parameter int                    V_ACTIVE          = 480
) (
  input logic                 clk,
  input logic                 reset,
  starfield_scroller_if.slave bus
);

  localparam int W = LFSR_WIDTH;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [W-1:0] SEED_INIT =
    (SEED == '0) ? {{(W-1){1'b0}}, 1'b1} : SEED;

  localparam int                   SCROLL_W    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [SCROLL_W-1:0]  SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);
  localparam logic [9:0]           H_LAST      = 10'(H_ACTIVE - 1);
  localparam logic [9:0]           V_LAST      = 10'(V_ACTIVE - 1);

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    return {s[W-2:0], ^(s & TAPS)};
  endfunction

  // Pattern generator state
  logic [W-1:0]        lfsr_q, lfsr_d;
  logic [W-1:0]        seed_q, seed_d;
  logic [SCROLL_W-1:0] scroll_q, scroll_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;

  // Stage 1
  logic       disp1_q, disp1_d;
  logic       hsync1_q, hsync1_d;
  logic       vsync1_q, vsync1_d;
  logic [2:0] bg1_q, bg1_d;
  logic       star1_q, star1_d;
  logic [2:0] col1_q, col1_d;

  // Stage 2
  logic [2:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  logic       frame_end;
  logic       scroll_tick;
  logic       star_on;
  logic       star_vis;
  logic [2:0] star_col;

  // The star decision is made from the pre-step LFSR value of this cycle.
  always_comb begin
    frame_end   = bus.display_on && (bus.hpos == H_LAST) && (bus.vpos == V_LAST);
    scroll_tick = frame_end && (scroll_q == SCROLL_LAST);
    star_on     = &lfsr_q[W-1 -: STAR_DENSITY_BITS];
    star_col    = (lfsr_q[2:0] == 3'b000) ? 3'b111 : lfsr_q[2:0];
`ifdef STARFIELD_TWINKLE_EN
    star_vis    = star_on && bus.star_en && !(lfsr_q[3] && frame_cnt_q[4]);
`else
    star_vis    = star_on && bus.star_en;
`endif
  end

  // Frame bookkeeping and LFSR sequencing. At the end of a frame the LFSR is
  // reloaded from seed_reg; stepping the seed once per scroll period makes the
  // next frame start where the previous one's second pixel started, which is
  // what produces the one-pixel leftward scroll.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    scroll_d    = scroll_q;
    seed_d      = seed_q;
    lfsr_d      = lfsr_q;
    if (frame_end) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (scroll_tick) begin
        scroll_d = '0;
        seed_d   = lfsr_step(seed_q);
      end else begin
        scroll_d = scroll_q + SCROLL_W'(1);
      end
      lfsr_d = seed_d;
    end else if (bus.display_on) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  // Two-stage pixel pipeline; sync signals travel alongside the colour so
  // everything leaving the block stays aligned.
  always_comb begin
    disp1_d  = bus.display_on;
    hsync1_d = bus.hsync_in;
    vsync1_d = bus.vsync_in;
    bg1_d    = bus.bg_rgb;
    star1_d  = star_vis;
    col1_d   = star_col;
    if (!disp1_q) begin
      rgb_d = 3'b000;
    end else if (star1_q) begin
      rgb_d = col1_q;
    end else begin
      rgb_d = bg1_q;
    end
    hsync_d = hsync1_q;
    vsync_d = vsync1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q      <= SEED_INIT;
      seed_q      <= SEED_INIT;
      scroll_q    <= '0;
      frame_cnt_q <= '0;
      disp1_q     <= 1'b0;
      hsync1_q    <= 1'b0;
      vsync1_q    <= 1'b0;
      bg1_q       <= '0;
      star1_q     <= 1'b0;
      col1_q      <= '0;
      rgb_q       <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      seed_q      <= seed_d;
      scroll_q    <= scroll_d;
      frame_cnt_q <= frame_cnt_d;
      disp1_q     <= disp1_d;
      hsync1_q    <= hsync1_d;
      vsync1_q    <= vsync1_d;
      bg1_q       <= bg1_d;
      star1_q     <= star1_d;
      col1_q      <= col1_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign bus.rgb       = rgb_q;
  assign bus.hsync     = hsync_q;
  assign bus.vsync     = vsync_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_starfield_scroller.sv
// tb_starfield_scroller
//   Drives two starfield_scroller instances with the same pixel stream:
//     dut0 : default parameters (SEED 1, density 7, scroll every frame)
//     dut1 : SEED 0, density 1, scroll every 3 frames
//   Expected pixels come from a reference model that derives each pixel's
//   LFSR state as "frame seed advanced by the number of active pixels already
//   drawn in this frame", with the frame seed itself being the reset seed
//   advanced once per completed scroll period.
module tb_starfield_scroller;

  localparam logic [15:0] TAPS_M = 16'b1000000001011;

  typedef struct packed {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
  } pix_t;

  typedef struct {
    logic       disp;
    logic       hs;
    logic       vs;
    logic [2:0] bg;
    logic       sen;
    logic [2:0] exp_rgb;
    logic       exp_hs;
    logic       exp_vs;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  // 100 MHz-style free-running pixel clock
  always #5 clk = ~clk;

  starfield_scroller_if bus0 ();
  starfield_scroller_if bus1 ();

  starfield_scroller dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  starfield_scroller #(
    .SEED              (16'h0000),
    .STAR_DENSITY_BITS (1),
    .SCROLL_DIV        (3)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // Current stimulus, shared by both instances
  logic       in_disp;
  logic [9:0] in_hpos;
  logic [9:0] in_vpos;
  logic       in_hs;
  logic       in_vs;
  logic [2:0] in_bg;
  logic       in_sen;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model configuration per instance (seed 0 becomes 1)
  logic [15:0] seed_init [2] = '{16'h0001, 16'h0001};
  int          dens      [2] = '{7, 1};
  int          sdiv      [2] = '{1, 3};

  // Reference model state: frames completed since reset, active pixels drawn
  // so far in the current frame, and a two-deep output delay line.
  int   frames;
  int   pix;
  pix_t p1 [2];
  pix_t p2 [2];

  vec_t vecs [9];

  function automatic logic [15:0] advance(input logic [15:0] s, input int n);
    logic [15:0] v;
    v = s;
    for (int k = 0; k < n; k++) v = {v[14:0], ^(v & TAPS_M)};
    return v;
  endfunction

  task automatic model_reset();
    frames = 0;
    pix    = 0;
    for (int i = 0; i < 2; i++) begin
      p1[i] = '0;
      p2[i] = '0;
    end
  endtask

  // One clock edge of the reference model using the inputs currently applied
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic [15:0] l;
      int          top;
      logic        star;
      logic [2:0]  col;
      pix_t        nxt;
      l    = advance(advance(seed_init[i], frames / sdiv[i]), pix);
      top  = int'(l) >> (16 - dens[i]);
      star = in_sen && (top == ((1 << dens[i]) - 1));
`ifdef STARFIELD_TWINKLE_EN
      if (l[3] && ((((frames % 256) / 16) % 2) == 1)) star = 1'b0;
`endif
      col     = (l[2:0] == 3'd0) ? 3'd7 : l[2:0];
      nxt.rgb = !in_disp ? 3'd0 : (star ? col : in_bg);
      nxt.hs  = in_hs;
      nxt.vs  = in_vs;
      p2[i]   = p1[i];
      p1[i]   = nxt;
    end
    if (in_disp && in_hpos == 10'd639 && in_vpos == 10'd479) begin
      frames++;
      pix = 0;
    end else if (in_disp) begin
      pix++;
    end
  endtask

  task automatic set_in(input logic d, input logic [9:0] h, input logic [9:0] v,
                        input logic hs, input logic vs, input logic [2:0] bg,
                        input logic sen);
    in_disp = d;
    in_hpos = h;
    in_vpos = v;
    in_hs   = hs;
    in_vs   = vs;
    in_bg   = bg;
    in_sen  = sen;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive both instances, advance one clock, then settle past the edge
  task automatic applyStimulus();
    bus0.display_on = in_disp; bus1.display_on = in_disp;
    bus0.hpos       = in_hpos; bus1.hpos       = in_hpos;
    bus0.vpos       = in_vpos; bus1.vpos       = in_vpos;
    bus0.hsync_in   = in_hs;   bus1.hsync_in   = in_hs;
    bus0.vsync_in   = in_vs;   bus1.vsync_in   = in_vs;
    bus0.bg_rgb     = in_bg;   bus1.bg_rgb     = in_bg;
    bus0.star_en    = in_sen;  bus1.star_en    = in_sen;
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  // Compare both instances against the reference model
  task automatic checkOutput();
    chk("dut0_rgb",   {5'd0, bus0.rgb},   {5'd0, p2[0].rgb});
    chk("dut0_hsync", {7'd0, bus0.hsync}, {7'd0, p2[0].hs});
    chk("dut0_vsync", {7'd0, bus0.vsync}, {7'd0, p2[0].vs});
    chk("dut0_frame_cnt", bus0.frame_cnt, 8'(frames % 256));
    chk("dut1_rgb",   {5'd0, bus1.rgb},   {5'd0, p2[1].rgb});
    chk("dut1_hsync", {7'd0, bus1.hsync}, {7'd0, p2[1].hs});
    chk("dut1_vsync", {7'd0, bus1.vsync}, {7'd0, p2[1].vs});
    chk("dut1_frame_cnt", bus1.frame_cnt, 8'(frames % 256));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_rgb0"}, {5'd0, bus0.rgb}, 8'd0);
    chk({tag, "_hs0"},  {7'd0, bus0.hsync}, 8'd0);
    chk({tag, "_vs0"},  {7'd0, bus0.vsync}, 8'd0);
    chk({tag, "_fc0"},  bus0.frame_cnt, 8'd0);
    chk({tag, "_rgb1"}, {5'd0, bus1.rgb}, 8'd0);
    chk({tag, "_hs1"},  {7'd0, bus1.hsync}, 8'd0);
    chk({tag, "_vs1"},  {7'd0, bus1.vsync}, 8'd0);
    chk({tag, "_fc1"},  bus1.frame_cnt, 8'd0);
  endtask

  initial begin
    logic [2:0] prev_exp;
    logic       roll_d;

    // Blanking vectors: {disp, hs, vs, bg, sen, exp_rgb, exp_hs, exp_vs};
    // each row's expectation is the previous row's input (two-clock latency).
    vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 3'd7, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 3'd0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 3'd2, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 3'd3, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 3'd0, 1'b0, 1'b0};

    // Reset held for 5 clocks with active video and a visible background
    reset = 1'b1;
    model_reset();
    set_in(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 3'b101, 1'b1);
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      check_cleared("reset_hold");
    end
    reset = 1'b0;
    applyStimulus();
    checkOutput();
    applyStimulus();
    checkOutput();
    chk("post_reset_rgb0_nonzero", {7'd0, bus0.rgb != 3'd0}, 8'd1);
    chk("post_reset_rgb1_nonzero", {7'd0, bus1.rgb != 3'd0}, 8'd1);

    // Two blank cycles so the table starts from a known pipeline
    set_in(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 3'd7, 1'b1);
    for (int c = 0; c < 2; c++) begin
      applyStimulus();
      checkOutput();
    end

    // Table: sync delay and blanking override
    for (int r = 0; r < 9; r++) begin
      set_in(vecs[r].disp, 10'd0, 10'd0, vecs[r].hs, vecs[r].vs, vecs[r].bg, vecs[r].sen);
      applyStimulus();
      checkOutput();
      chk($sformatf("vec%0d_rgb0", r), {5'd0, bus0.rgb},   {5'd0, vecs[r].exp_rgb});
      chk($sformatf("vec%0d_rgb1", r), {5'd0, bus1.rgb},   {5'd0, vecs[r].exp_rgb});
      chk($sformatf("vec%0d_hs0", r),  {7'd0, bus0.hsync}, {7'd0, vecs[r].exp_hs});
      chk($sformatf("vec%0d_vs1", r),  {7'd0, bus1.vsync}, {7'd0, vecs[r].exp_vs});
    end

    // Stars disabled for a whole mini-frame: background only, black in blanking
    prev_exp = 3'd0;
    for (int px = 0; px <= 40; px++) begin
      roll_d = (px % 5) != 4;
      if (px == 40) set_in(1'b1, 10'd639, 10'd479, 1'b0, 1'b0, 3'b010, 1'b0);
      else          set_in(roll_d, 10'(px), 10'd0, 1'b0, 1'b0, 3'b010, 1'b0);
      applyStimulus();
      checkOutput();
      chk("nostar_rgb0", {5'd0, bus0.rgb}, {5'd0, prev_exp});
      chk("nostar_rgb1", {5'd0, bus1.rgb}, {5'd0, prev_exp});
      prev_exp = in_disp ? 3'b010 : 3'd0;
    end

    // Randomised traffic with occasional frame ends and one mid-frame reset
    for (int c = 0; c < 2000; c++) begin
      int roll;
      roll = int'($urandom_range(0, 19));
      set_in($urandom_range(0, 3) != 0,
             10'($urandom_range(0, 799)), 10'($urandom_range(0, 524)),
             $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
             3'($urandom_range(0, 7)), $urandom_range(0, 9) != 0);
      if (roll == 0) begin
        in_hpos = 10'd639;
        in_vpos = 10'd479;
      end else if (roll == 1) begin
        in_hpos = 10'd639;
      end else if (roll == 2) begin
        in_vpos = 10'd479;
      end
      applyStimulus();
      checkOutput();
      if (c == 900) begin
        #2;
        reset = 1'b1;
        #1;
        check_cleared("midframe_reset");
        model_reset();
        applyStimulus();
        check_cleared("midframe_reset_held");
        reset = 1'b0;
      end
    end

    // Back-to-back frame ends to walk frame_cnt through its wrap
    for (int c = 0; c < 260; c++) begin
      set_in(1'b1, 10'd639, 10'd479, 1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'b1);
      applyStimulus();
      checkOutput();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/starfield_scroller.md
Name: starfield_scroller

Overview:
- Pixel-stream stage directly downstream of the vga timing generator. Consumes hpos/vpos/display_on/hsync/vsync and a background colour from the pattern logic, and drives the board rgb/hsync/vsync pins.
- Overlays a pseudo-random starfield that scrolls horizontally by one pixel per N frames, using an LFSR reseeded every frame.
- Registered two-stage pipeline; all outputs are delay-matched.

Parameters:
- LFSR_WIDTH, 16, LFSR width; must be at least 8.
- TAPS, 16'b1000000001011, Fibonacci feedback tap mask; bit i set means lfsr[i] is XORed into feedback.
- SEED, 16'h0001, initial seed. A zero value is replaced by 1.
- STAR_DENSITY_BITS, 7, number of LFSR MSBs that must all be 1 for a star; range 1..LFSR_WIDTH-3.
- SCROLL_DIV, 1, frames per one-pixel scroll step; must be at least 1.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- display_on  in  1  active-video flag from timing generator
- hpos  in  10  current pixel column
- vpos  in  10  current line
- hsync_in  in  1  horizontal sync from timing generator
- vsync_in  in  1  vertical sync from timing generator
- bg_rgb  in  3  background colour for the current pixel
- star_en  in  1  1 = overlay stars, 0 = pass background through
- hsync  out  1  delayed hsync_in
- vsync  out  1  delayed vsync_in
- rgb  out  3  final pixel colour
- frame_cnt  out  8  completed-frame counter, wraps at 255 to 0

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous, active-high.
- Reset values:
  - rgb = 0, hsync = 0, vsync = 0, frame_cnt = 0.
  - lfsr = seed_reg = (SEED==0 ? 1 : SEED); scroll counter = 0.
  - All pipeline registers = 0.
- LFSR stepping:
  - Fibonacci: next = {lfsr[W-2:0], ^(lfsr & TAPS)}.
  - Steps exactly once per clock in which display_on = 1 and the cycle is not frame_end.
  - Holds when display_on = 0.
- frame_end = display_on & (hpos == H_ACTIVE-1) & (vpos == V_ACTIVE-1). On a frame_end cycle:
  - frame_cnt increments.
  - Scroll counter increments. When it reaches SCROLL_DIV-1 it wraps to 0 and seed_reg steps once (scroll tick).
  - lfsr loads the updated seed_reg: the stepped value on a scroll tick, otherwise the unchanged value.
  - Net effect: first active pixel of frame k+1 uses the state that the second active pixel of frame k used, so the pattern shifts left one pixel per SCROLL_DIV frames.
- Star decision uses the current-cycle lfsr (pre-step value):
  - star_on = &lfsr[W-1 : W-STAR_DENSITY_BITS].
  - star_col = (lfsr[2:0] == 0) ? 3'b111 : lfsr[2:0]. Stars are never black.
- Pipeline stage 1 registers display_on, hsync_in, vsync_in, bg_rgb, star_on & star_en, star_col.
- Pipeline stage 2 registers:
  - rgb = !disp_d ? 0 : (star_d ? col_d : bg_d).
  - hsync/vsync from stage 1.
- Latency: exactly 2 clocks from every input to rgb/hsync/vsync. frame_cnt updates 1 clock after frame_end.
- star_en = 0: the LFSR still advances, so the pattern phase is preserved when re-enabled.
- Blanking (display_on = 0): rgb is forced to 0 regardless of bg_rgb or stars.
- Reset mid-frame:
  - Outputs clear immediately.
  - After release, the LFSR restarts from the seed, so the partial frame pattern is misaligned.
  - Alignment is restored from the next frame_end onward.
- hpos/vpos values outside the active area are ignored except through display_on.

Optional Feature:
- Macro: STARFIELD_TWINKLE_EN.
- Defined: a star is additionally suppressed when lfsr[3] == 1 and frame_cnt[4] == 1, so half of the stars blink with a 32-frame period.
- Undefined: no suppression; behaviour exactly as above and frame_cnt[4] has no effect on rgb.

Test Plan:
- Reset held 5 clocks with display_on = 1 and bg_rgb = 3'b101 -> rgb = 0, hsync = vsync = 0, frame_cnt = 0. After release, rgb = 3'b101 or a star colour 2 clocks later.
- Single-cycle hsync_in pulse at cycle N with display_on = 0 and bg_rgb = 3'b111 -> hsync high exactly at cycle N+2 for 1 clock; rgb stays 0 throughout.
- star_en = 0, bg_rgb = 3'b010, full frame -> rgb = 3'b010 on every active pixel and 0 in blanking. Re-enable star_en -> star positions equal a reference model with no phase loss.
- SCROLL_DIV = 1, two consecutive frames -> lfsr at (0,0) of frame k+1 equals lfsr at (1,0) of frame k. frame_cnt goes 0 -> 1 -> 2 one clock after each frame_end.
- SCROLL_DIV = 3 -> seed_reg changes only at frame_cnt transitions 2->3 and 5->6; frames 0-2 show identical star maps.
- SEED = 0, STAR_DENSITY_BITS = 1 -> lfsr = 1 after reset (no lockup), and rgb is nonzero on active pixels whose lfsr[15] = 1. With STARFIELD_TWINKLE_EN defined, stars with lfsr[3] = 1 vanish during frames 16-31.
